// File: rtl/mux_pipe_n.sv
// Registered N-way selector with valid/ready handshake and a 2-entry (output + skid) buffer.
// Optional MUX_PIPE_SEL_CHECK_EN flags beats whose select is >= WAYS on out_err.
module mux_pipe_n #(
  parameter int WIDTH = 32,
  parameter int WAYS  = 4,
  parameter int SEL_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [WAYS*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_err
);

  localparam int NCH = 1 << SEL_W;

  typedef struct packed {
    logic             vld;
    logic             err;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] dat;
  } beat_t;

  // Select codes beyond WAYS map to zero-filled channels, so no compare is needed for out_data.
  logic [WIDTH-1:0] chan [NCH];
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    if (k < WAYS) begin : g_real
      assign chan[k] = in_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  beat_t o_q, o_d;
  beat_t s_q, s_d;
  beat_t in_beat;
  logic  accept;

`ifdef MUX_PIPE_SEL_CHECK_EN
  localparam logic [SEL_W:0] WAYS_L = (SEL_W+1)'(WAYS);
  logic sel_bad;
  assign sel_bad = ({1'b0, in_sel} >= WAYS_L);
`else
  logic sel_bad;
  assign sel_bad = 1'b0;
`endif

  always_comb begin
    in_beat     = '0;
    in_beat.vld = 1'b1;
    in_beat.err = sel_bad;
    in_beat.sel = in_sel;
    in_beat.dat = chan[in_sel];
  end

  // in_ready depends only on state and reset, never on out_ready.
  assign in_ready = !s_q.vld && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    o_d = o_q;
    s_d = s_q;
    if (!o_q.vld || out_ready) begin
      if (s_q.vld) begin
        o_d     = s_q;
        s_d.vld = 1'b0;
      end else if (accept) begin
        o_d = in_beat;
      end else begin
        o_d.vld = 1'b0;
      end
    end else if (accept) begin
      s_d = in_beat;
    end
    if (flush) begin
      o_d.vld = 1'b0;
      s_d.vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_q <= '0;
      s_q <= '0;
    end else begin
      o_q <= o_d;
      s_q <= s_d;
    end
  end

`ifdef MUX_PIPE_SEL_CHECK_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && accept && sel_bad)
      $display("mux_pipe_n warning: out-of-range select %0d captured (WAYS=%0d)", in_sel, WAYS);
  end
`endif
`endif

  assign out_data  = o_q.dat;
  assign out_sel   = o_q.sel;
  assign out_valid = o_q.vld;
  assign out_err   = o_q.err;

endmodule
